// File: rtl/register_file_3p_pkg.sv
// Core-wide storage constants and types shared by the register file, the
// address generation unit and the ALU.
package register_file_3p_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 7;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef data_t [DEPTH-1:0]     mem_t;

  // A read hits the writeback path when it targets the entry being written.
  function automatic logic fwd_hit(input addr_t r_addr, input addr_t w_addr, input logic w_en);
    return w_en && (r_addr == w_addr);
  endfunction

endpackage

// File: rtl/register_file_3p_if.sv
// Read/write bus of the three-port register file; the core side is master,
// the register file is slave.
interface register_file_3p_if;
  import register_file_3p_pkg::*;

  addr_t r_addr_a;
  addr_t r_addr_b;
  logic  r_en;
  addr_t w_addr;
  logic  w_en;
  data_t w_data;
  data_t r_data_a;
  data_t r_data_b;

  modport master (
    output r_addr_a, r_addr_b, r_en, w_addr, w_en, w_data,
    input  r_data_a, r_data_b
  );

  modport slave (
    input  r_addr_a, r_addr_b, r_en, w_addr, w_en, w_data,
    output r_data_a, r_data_b
  );

endinterface

// File: rtl/register_file_3p_rf_read_port.sv
// One registered read port: array mux, write-first forwarding and a hold
// register that freezes the output while r_en is low.
module rf_read_port
  import register_file_3p_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  mem_t  mem,
  input  addr_t r_addr,
  input  logic  r_en,
  input  addr_t w_addr,
  input  logic  w_en,
  input  data_t w_data,
  output data_t r_data
);

  data_t r_data_q;
  data_t r_data_d;

  // The array still holds the old value this cycle, so a colliding write is
  // taken straight from the writeback bus.
  always_comb begin
    r_data_d = r_data_q;
    if (r_en) begin
      r_data_d = fwd_hit(r_addr, w_addr, w_en) ? w_data : mem[r_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_q <= '0;
    end else begin
      r_data_q <= r_data_d;
    end
  end

  assign r_data = r_data_q;

endmodule

// File: rtl/register_file_3p.sv
// Physical general-purpose register file: flop array with synchronous clear,
// one write port and two registered read ports.
module register_file_3p
  import register_file_3p_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  register_file_3p_if.slave  rf
);

  mem_t mem_view;

  // Flops rather than block RAM: every entry must clear in a single cycle.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      data_t entry_q;
      data_t entry_d;

      always_comb begin
        entry_d = entry_q;
        if (rf.w_en && (rf.w_addr == ADDR_WIDTH'(gi))) begin
          entry_d = rf.w_data;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          entry_q <= '0;
        end else begin
          entry_q <= entry_d;
        end
      end

      assign mem_view[gi] = entry_q;
    end
  endgenerate

  data_t r_data_a_w;
  data_t r_data_b_w;

  rf_read_port u_port_a (
    .clk    (clk),
    .reset  (reset),
    .mem    (mem_view),
    .r_addr (rf.r_addr_a),
    .r_en   (rf.r_en),
    .w_addr (rf.w_addr),
    .w_en   (rf.w_en),
    .w_data (rf.w_data),
    .r_data (r_data_a_w)
  );

  rf_read_port u_port_b (
    .clk    (clk),
    .reset  (reset),
    .mem    (mem_view),
    .r_addr (rf.r_addr_b),
    .r_en   (rf.r_en),
    .w_addr (rf.w_addr),
    .w_en   (rf.w_en),
    .w_data (rf.w_data),
    .r_data (r_data_b_w)
  );

  assign rf.r_data_a = r_data_a_w;
  assign rf.r_data_b = r_data_b_w;

endmodule

// File: tb/tb_register_file_3p.sv
// Self-checking bench for register_file_3p: directed steps plus random traffic
// compared every cycle against an array-based reference model.
module tb_register_file_3p;
  import register_file_3p_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  register_file_3p_if rf_if ();

  register_file_3p dut (
    .clk   (clk),
    .reset (reset),
    .rf    (rf_if)
  );

  int    total = 0;
  int    bad   = 0;
  data_t ref_mem [DEPTH];
  data_t exp_a = '0;
  data_t exp_b = '0;

  task automatic check(input string tag, input data_t got, input data_t exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic re, input logic we,
                       input addr_t ra, input addr_t rb, input addr_t wa, input data_t wd);
    reset          = rst;
    rf_if.r_en     = re;
    rf_if.w_en     = we;
    rf_if.r_addr_a = ra;
    rf_if.r_addr_b = rb;
    rf_if.w_addr   = wa;
    rf_if.w_data   = wd;
  endtask

  // Reference model: apply the behavioural rules to the inputs present before
  // the edge, then compare both outputs just after it.
  task automatic tick();
    if (reset) begin
      foreach (ref_mem[i]) ref_mem[i] = '0;
      exp_a = '0;
      exp_b = '0;
    end else begin
      if (rf_if.r_en) begin
        exp_a = (rf_if.w_en && rf_if.w_addr == rf_if.r_addr_a) ? rf_if.w_data : ref_mem[rf_if.r_addr_a];
        exp_b = (rf_if.w_en && rf_if.w_addr == rf_if.r_addr_b) ? rf_if.w_data : ref_mem[rf_if.r_addr_b];
      end
      if (rf_if.w_en) ref_mem[rf_if.w_addr] = rf_if.w_data;
    end
    @(posedge clk);
    #1;
    check("model_a", rf_if.r_data_a, exp_a);
    check("model_b", rf_if.r_data_b, exp_b);
  endtask

  function automatic addr_t win_addr(input int sr, input int k);
    logic [3:0] s;
    logic [2:0] r;
    s = sr[3:0];
    r = k[2:0];
    return {s, r};
  endfunction

  function automatic data_t win_data(input int sr, input int k);
    logic [3:0] s;
    logic [2:0] r;
    s = sr[3:0];
    r = k[2:0];
    return {s, 4'hA, 5'b0, r};
  endfunction

  initial begin
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);

    // 1: reset, then read the lowest and highest entries
    tick();
    drive(1'b0, 1'b1, 1'b0, 7'h00, 7'h7F, '0, '0);
    tick();
    check("t1_a_zero", rf_if.r_data_a, 16'h0000);
    check("t1_b_zero", rf_if.r_data_b, 16'h0000);
    $display("txn t1 reset/read a=%h b=%h", rf_if.r_data_a, rf_if.r_data_b);

    // 2: write, then read one cycle later
    drive(1'b0, 1'b0, 1'b1, '0, '0, 7'h15, 16'hBEEF);
    tick();
    drive(1'b0, 1'b1, 1'b0, 7'h15, 7'h00, '0, '0);
    tick();
    check("t2_read_beef", rf_if.r_data_a, 16'hBEEF);
    $display("txn t2 write/read a=%h", rf_if.r_data_a);

    // 3: same-cycle write and read on both ports
    drive(1'b0, 1'b1, 1'b1, 7'h22, 7'h22, 7'h22, 16'h1234);
    tick();
    check("t3_fwd_a", rf_if.r_data_a, 16'h1234);
    check("t3_fwd_b", rf_if.r_data_b, 16'h1234);
    $display("txn t3 forward a=%h b=%h", rf_if.r_data_a, rf_if.r_data_b);

    // 4: hold under stall while the entry is overwritten
    drive(1'b0, 1'b1, 1'b0, 7'h15, 7'h22, '0, '0);
    tick();
    check("t4_pre_beef", rf_if.r_data_a, 16'hBEEF);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 7'h15, 7'h22, 7'h15, 16'h0F0F);
      tick();
      check("t4_hold_beef", rf_if.r_data_a, 16'hBEEF);
      check("t4_hold_b", rf_if.r_data_b, 16'h1234);
    end
    drive(1'b0, 1'b1, 1'b0, 7'h15, 7'h22, '0, '0);
    tick();
    check("t4_new_0f0f", rf_if.r_data_a, 16'h0F0F);
    $display("txn t4 stall/release a=%h", rf_if.r_data_a);

    // 5: reset clears the array and drops a concurrent write
    drive(1'b0, 1'b0, 1'b1, '0, '0, 7'h7F, 16'hAAAA);
    tick();
    drive(1'b1, 1'b1, 1'b1, 7'h7F, 7'h7F, 7'h7F, 16'h5555);
    tick();
    check("t5_reset_out", rf_if.r_data_a, 16'h0000);
    drive(1'b0, 1'b1, 1'b0, 7'h7F, 7'h7F, '0, '0);
    tick();
    check("t5_cleared_a", rf_if.r_data_a, 16'h0000);
    check("t5_cleared_b", rf_if.r_data_b, 16'h0000);
    $display("txn t5 reset-clear a=%h b=%h", rf_if.r_data_a, rf_if.r_data_b);

    // 6: windowed sweep, unique data per window, no aliasing
    for (int sr = 0; sr < 16; sr++) begin
      for (int k = 0; k < 8; k++) begin
        drive(1'b0, 1'b0, 1'b1, '0, '0, win_addr(sr, k), win_data(sr, k));
        tick();
      end
    end
    for (int sr = 0; sr < 16; sr++) begin
      for (int k = 0; k < 8; k++) begin
        drive(1'b0, 1'b1, 1'b0, win_addr(sr, k), win_addr(15 - sr, 7 - k), '0, '0);
        tick();
        check("t6_win_a", rf_if.r_data_a, win_data(sr, k));
        check("t6_win_b", rf_if.r_data_b, win_data(15 - sr, 7 - k));
      end
      $display("txn t6 window %0d read back", sr);
    end

    // Random traffic with frequent address collisions and occasional reset
    for (int n = 0; n < 600; n++) begin
      addr_t wa;
      addr_t ra;
      addr_t rb;
      wa = addr_t'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? wa : addr_t'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? wa : addr_t'($urandom);
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 1) == 1), ra, rb, wa, data_t'($urandom));
      tick();
    end
    $display("txn random traffic complete");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
